// File: rtl/calc1_port_responder.sv
// Responder end of one calc1 port: takes a command with operand 1, operand 2 on the next cycle, and answers after LATENCY cycles.
// Optional drop counter output is enabled by defining CALC1_RESP_DROP_CNT_EN.
module calc1_port_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
`ifdef CALC1_RESP_DROP_CNT_EN
  ,
  output logic [0:7]  drop_count
`endif
);

  // Protocol: a non-NOP req_cmd_in is accepted only in IDLE or RESP; the next cycle's
  // req_data_in is operand 2. out_resp/out_data are a one-cycle pulse, with no backpressure.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_LSH = 4'd5;
  localparam logic [0:3] CMD_RSH = 4'd6;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [0:3]  cmd_q, cmd_nxt;
  logic [0:31] op1_q, op1_nxt;
  logic [0:31] op2_q, op2_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic        accept;

  logic [0:32] sum;
  logic [0:4]  shamt;
  logic [0:1]  res_resp;
  logic [0:31] res_data;

  assign accept = (req_cmd_in != 4'd0);

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state <= IDLE;
      cmd_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
      op1_q <= op1_nxt;
      op2_q <= op2_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    op1_nxt   = op1_q;
    op2_nxt   = op2_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          cmd_nxt   = req_cmd_in;
          op1_nxt   = req_data_in;
          state_nxt = OP2;
        end
      end
      OP2: begin
        // Operand 2 is taken whatever req_cmd_in carries this cycle.
        op2_nxt = req_data_in;
        if (LAT_M1 == 4'd0) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_M1;
        end
      end
      WAIT: begin
        // Counter runs LAT_M1 down to 0; the edge seen at 0 enters RESP,
        // placing the response LATENCY edges after operand 2.
        if (cnt_q == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (accept) begin
          cmd_nxt   = req_cmd_in;
          op1_nxt   = req_data_in;
          state_nxt = OP2;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sum   = {1'b0, op1_q} + {1'b0, op2_q};
  assign shamt = op2_q[27:31];

  always_comb begin
    res_resp = 2'd2;
    res_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[0]) begin
          res_resp = 2'd1;
          res_data = sum[1:32];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_resp = 2'd1;
          res_data = op1_q - op2_q;
        end
      end
      CMD_LSH: begin
        res_resp = 2'd1;
        res_data = op1_q << shamt;
      end
      CMD_RSH: begin
        res_resp = 2'd1;
        res_data = op1_q >> shamt;
      end
      default: begin
        res_resp = 2'd2;
        res_data = '0;
      end
    endcase
  end

  assign out_resp = (state == RESP) ? res_resp : 2'd0;
  assign out_data = (state == RESP) ? res_data : 32'd0;
  assign busy     = (state == OP2) || (state == WAIT);

`ifdef CALC1_RESP_DROP_CNT_EN
  logic drop;
  assign drop = (state == WAIT) && accept;

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

  assert property (@(posedge c_clk) out_resp != 2'd3);
  assert property (@(posedge c_clk) !(busy && (out_resp != 2'd0)));

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder: arithmetic, timing, drop rule, back-to-back and reset abort.
module tb_calc1_port_responder;

  localparam int LAT = 3;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;
`ifdef CALC1_RESP_DROP_CNT_EN
  logic [0:7]  drop_count;
`endif

  int errors = 0;
  int checks = 0;

  calc1_port_responder #(.LATENCY(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
`ifdef CALC1_RESP_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  // clock / reset
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic cycle();
    @(posedge c_clk);
    #1;
  endtask

  // driver: full transaction, capturing the response and quiet flags around it
  task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] resp, output logic [31:0] data,
                        output bit busy_ok, output bit early_quiet, output bit late_quiet);
    req_cmd_in  = cmd;
    req_data_in = a;
    cycle();
    busy_ok     = (busy === 1'b1);
    req_cmd_in  = 4'd0;
    req_data_in = b;
    cycle();
    early_quiet = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      req_data_in = $urandom;
      if (i == LAT - 1) cycle();
      else begin
        cycle();
        if (out_resp !== 2'd0 || out_data !== 32'd0) early_quiet = 1'b0;
      end
    end
    resp = out_resp;
    data = out_data;
    if (busy !== 1'b0) busy_ok = 1'b0;
    cycle();
    late_quiet = (out_resp === 2'd0) && (out_data === 32'd0);
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = 32'd0;
    cycle();
    checks++;
    if (out_resp !== 2'd0 || out_data !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: resp=%0d data=%h busy=%b, need 0/0/0", out_resp, out_data, busy);
    end
`ifdef CALC1_RESP_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_count: got %0d need 0", drop_count);
    end
`endif
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_arith();
    logic [3:0]  cmd_v [9];
    logic [31:0] a_v   [9];
    logic [31:0] b_v   [9];
    logic [1:0]  er_v  [9];
    logic [31:0] ed_v  [9];
    logic [1:0]  r;
    logic [31:0] d;
    bit          bok, eq, lq;
    cmd_v[0] = 4'd1; a_v[0] = 32'hFFFF0000; b_v[0] = 32'h0000FFFF; er_v[0] = 2'd1; ed_v[0] = 32'hFFFFFFFF;
    cmd_v[1] = 4'd1; a_v[1] = 32'hFFFFFFFF; b_v[1] = 32'h00000001; er_v[1] = 2'd2; ed_v[1] = 32'h0;
    cmd_v[2] = 4'd2; a_v[2] = 32'd5;        b_v[2] = 32'd6;        er_v[2] = 2'd2; ed_v[2] = 32'h0;
    cmd_v[3] = 4'd2; a_v[3] = 32'd100;      b_v[3] = 32'd1;        er_v[3] = 2'd1; ed_v[3] = 32'd99;
    cmd_v[4] = 4'd2; a_v[4] = 32'd7;        b_v[4] = 32'd7;        er_v[4] = 2'd1; ed_v[4] = 32'd0;
    cmd_v[5] = 4'd5; a_v[5] = 32'h00000001; b_v[5] = 32'h00000021; er_v[5] = 2'd1; ed_v[5] = 32'h00000002;
    cmd_v[6] = 4'd5; a_v[6] = 32'h000000A5; b_v[6] = 32'hFFFFFFE0; er_v[6] = 2'd1; ed_v[6] = 32'h000000A5;
    cmd_v[7] = 4'd6; a_v[7] = 32'h80000000; b_v[7] = 32'd31;       er_v[7] = 2'd1; ed_v[7] = 32'h00000001;
    cmd_v[8] = 4'd3; a_v[8] = 32'd7;        b_v[8] = 32'd9;        er_v[8] = 2'd2; ed_v[8] = 32'h0;
    for (int i = 0; i < 9; i++) begin
      run_op(cmd_v[i], a_v[i], b_v[i], r, d, bok, eq, lq);
      checks++;
      if (r !== er_v[i] || d !== ed_v[i]) begin
        errors++;
        $display("FAIL arith_%0d: resp=%0d data=%h, need resp=%0d data=%h", i, r, d, er_v[i], ed_v[i]);
      end
      checks++;
      if (!bok || !eq || !lq) begin
        errors++;
        $display("FAIL timing_%0d: busy_ok=%0d quiet_before=%0d quiet_after=%0d, need 1/1/1", i, bok, eq, lq);
      end
    end
  endtask

  task automatic test_nop();
    bit quiet = 1'b1;
    req_cmd_in = 4'd0;
    for (int i = 0; i < 20; i++) begin
      req_data_in = $urandom;
      cycle();
      if (out_resp !== 2'd0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL nop_idle: activity seen=%0d need 0", !quiet);
    end
  endtask

  task automatic test_back_to_back();
    bit quiet;
    // ADD 1+2 at T, ADD 4+8 at T+2 lands in WAIT and is dropped
    req_cmd_in = 4'd1; req_data_in = 32'd1; cycle();
    req_cmd_in = 4'd0; req_data_in = 32'd2; cycle();
    req_cmd_in = 4'd1; req_data_in = 32'd4; cycle();
    req_cmd_in = 4'd0; req_data_in = 32'd8; cycle();
    checks++;
    if (out_resp !== 2'd0) begin
      errors++;
      $display("FAIL drop_early: resp=%0d need 0", out_resp);
    end
    cycle();
    checks++;
    if (out_resp !== 2'd1 || out_data !== 32'd3) begin
      errors++;
      $display("FAIL drop_resp: resp=%0d data=%h need 1/00000003", out_resp, out_data);
    end
    // ADD 4+8 presented during RESP is accepted
    req_cmd_in = 4'd1; req_data_in = 32'd4; cycle();
    checks++;
    if (out_resp !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: resp=%0d busy=%b need 0/1", out_resp, busy);
    end
    req_cmd_in = 4'd0; req_data_in = 32'd8; cycle();
    quiet = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      req_data_in = $urandom;
      cycle();
      if (out_resp !== 2'd0) quiet = 1'b0;
    end
    cycle();
    checks++;
    if (!quiet || out_resp !== 2'd1 || out_data !== 32'd12) begin
      errors++;
      $display("FAIL b2b_resp: quiet=%0d resp=%0d data=%h need 1/1/0000000c", quiet, out_resp, out_data);
    end
`ifdef CALC1_RESP_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_count: got %0d need 1", drop_count);
    end
`endif
    cycle();
    checks++;
    if (out_resp !== 2'd0) begin
      errors++;
      $display("FAIL b2b_after: resp=%0d need 0", out_resp);
    end
  endtask

  task automatic test_reset_abort();
    bit          quiet;
    logic [1:0]  r;
    logic [31:0] d;
    bit          bok, eq, lq;
    req_cmd_in = 4'd1; req_data_in = 32'd5; cycle();
    req_cmd_in = 4'd0; req_data_in = 32'd5; cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_resp !== 2'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b resp=%0d data=%h need 0/0/0", busy, out_resp, out_data);
    end
`ifdef CALC1_RESP_DROP_CNT_EN
    checks++;
    if (drop_count !== 8'd0) begin
      errors++;
      $display("FAIL abort_drop_count: got %0d need 0", drop_count);
    end
`endif
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (out_resp !== 2'd0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL abort_quiet: response or busy seen after reset=%0d need 0", !quiet);
    end
    run_op(4'd1, 32'd1, 32'd1, r, d, bok, eq, lq);
    checks++;
    if (r !== 2'd1 || d !== 32'd2 || !bok || !eq || !lq) begin
      errors++;
      $display("FAIL abort_next: resp=%0d data=%h flags=%0d%0d%0d need 1/00000002/111", r, d, bok, eq, lq);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_nop();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
